// File: rtl/voice_note_ctrl_pkg.sv
// Shared types and default sizing for the per-voice note controller.
// Envelope state encodings are fixed because the synth datapath decodes them.
package voice_note_ctrl_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  localparam int DEF_N_VOICES     = 4;
  localparam int DEF_FCW_W        = 24;
  localparam int DEF_AMP_W        = 8;
  localparam int DEF_TICK_DIV     = 1024;
  localparam int DEF_ATTACK_STEP  = 1;
  localparam int DEF_RELEASE_STEP = 1;
  localparam int WDATA_W          = 32;

endpackage

// File: rtl/voice_note_ctrl_if.sv
// MMIO store-decode command bus into the note controller, plus the packed
// per-voice status it returns to the NCO/mixer.
interface voice_note_ctrl_if
  import voice_note_ctrl_pkg::*;
#(
  parameter int N_VOICES = DEF_N_VOICES,
  parameter int FCW_W    = DEF_FCW_W,
  parameter int AMP_W    = DEF_AMP_W
);
  logic [WDATA_W-1:0]        wdata;
  logic [N_VOICES-1:0]       voice_we;
  logic                      fcw_we;
  logic                      note_start_we;
  logic                      note_release_we;
  logic                      reset_we;

  logic [N_VOICES*FCW_W-1:0] fcw;
  logic [N_VOICES*AMP_W-1:0] amp;
  logic [N_VOICES-1:0]       note_active;
  logic [N_VOICES-1:0]       note_finished;

  modport master (
    output wdata, voice_we, fcw_we, note_start_we, note_release_we, reset_we,
    input  fcw, amp, note_active, note_finished
  );

  modport slave (
    input  wdata, voice_we, fcw_we, note_start_we, note_release_we, reset_we,
    output fcw, amp, note_active, note_finished
  );
endinterface

// File: rtl/voice_note_ctrl_voice_env.sv
// One voice: FCW register, attack/sustain/release FSM with a saturating
// linear amplitude, and a sticky finished flag.
module voice_note_ctrl_voice_env
  import voice_note_ctrl_pkg::*;
#(
  parameter int FCW_W        = DEF_FCW_W,
  parameter int AMP_W        = DEF_AMP_W,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             sel,
  input  logic [FCW_W-1:0] wdata,
  input  logic             fcw_we,
  input  logic             note_start_we,
  input  logic             note_release_we,
  input  logic             reset_we,
  output logic [FCW_W-1:0] fcw,
  output logic [AMP_W-1:0] amp,
  output logic             active,
  output logic             finished
);

  localparam logic [AMP_W:0] AMP_MAX = {1'b0, {AMP_W{1'b1}}};
  localparam logic [AMP_W:0] A_STEP  = (AMP_W+1)'(ATTACK_STEP);
  localparam logic [AMP_W:0] R_STEP  = (AMP_W+1)'(RELEASE_STEP);

  env_state_e     state;
  logic [AMP_W:0] amp_up;
  logic [AMP_W:0] amp_dn;
  logic           env_cmd;

  // One extra bit so overflow/underflow is visible before saturating.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    amp_up  = {1'b0, amp} + A_STEP;
    amp_dn  = {1'b0, amp} - R_STEP;
    env_cmd = sel & (reset_we | note_start_we | note_release_we);
  end

  // NOTE: sequential state uses non-blocking assignments only; a later assignment
  // in the same cycle overrides an earlier one, which is how reset_we beats fcw_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ENV_IDLE;
      fcw      <= '0;
      amp      <= '0;
      active   <= 1'b0;
      finished <= 1'b0;
    end else begin
      if (sel && fcw_we) fcw <= wdata;

      if (sel && reset_we) begin
        state    <= ENV_IDLE;
        fcw      <= '0;
        amp      <= '0;
        active   <= 1'b0;
        finished <= 1'b0;
      end else if (sel && note_start_we) begin
        state    <= ENV_ATTACK;
        active   <= 1'b1;
        finished <= 1'b0;
      end else if (sel && note_release_we) begin
        if (state == ENV_ATTACK || state == ENV_SUSTAIN) state <= ENV_RELEASE;
      end else if (tick && !env_cmd) begin
        unique case (state)
          ENV_ATTACK: begin
            if (amp_up >= AMP_MAX) begin
              amp   <= AMP_MAX[AMP_W-1:0];
              state <= ENV_SUSTAIN;
            end else begin
              amp <= amp_up[AMP_W-1:0];
            end
          end
          ENV_RELEASE: begin
            if (amp_dn[AMP_W] || amp_dn == '0) begin
              amp      <= '0;
              state    <= ENV_IDLE;
              active   <= 1'b0;
              finished <= 1'b1;
            end else begin
              amp <= amp_dn[AMP_W-1:0];
            end
          end
          ENV_SUSTAIN: amp <= amp;
          default:     amp <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/voice_note_ctrl.sv
// Per-voice note controller: shared envelope prescaler, one envelope per
// voice, and packing of the voice status onto the command bus.
module voice_note_ctrl
  import voice_note_ctrl_pkg::*;
#(
  parameter int N_VOICES     = DEF_N_VOICES,
  parameter int FCW_W        = DEF_FCW_W,
  parameter int AMP_W        = DEF_AMP_W,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP
) (
  input logic             clk,
  input logic             rst,
  voice_note_ctrl_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  logic [FCW_W-1:0] fcw_v      [N_VOICES];
  logic [AMP_W-1:0] amp_v      [N_VOICES];
  logic             active_v   [N_VOICES];
  logic             finished_v [N_VOICES];

  // Free-running; commands never disturb the tick phase.
  always_ff @(posedge clk) begin
    if (rst || cnt == CNT_LAST) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_LAST);

  for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
    voice_note_ctrl_voice_env #(
      .FCW_W        (FCW_W),
      .AMP_W        (AMP_W),
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
      .clk             (clk),
      .rst             (rst),
      .tick            (tick),
      .sel             (bus.voice_we[i]),
      .wdata           (bus.wdata[FCW_W-1:0]),
      .fcw_we          (bus.fcw_we),
      .note_start_we   (bus.note_start_we),
      .note_release_we (bus.note_release_we),
      .reset_we        (bus.reset_we),
      .fcw             (fcw_v[i]),
      .amp             (amp_v[i]),
      .active          (active_v[i]),
      .finished        (finished_v[i])
    );
  end

  always_comb begin
    bus.fcw           = '0;
    bus.amp           = '0;
    bus.note_active   = '0;
    bus.note_finished = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      bus.fcw[i*FCW_W +: FCW_W] = fcw_v[i];
      bus.amp[i*AMP_W +: AMP_W] = amp_v[i];
      bus.note_active[i]        = active_v[i];
      bus.note_finished[i]      = finished_v[i];
    end
  end

endmodule

// File: tb/tb_voice_note_ctrl.sv
// Scoreboard bench for voice_note_ctrl: directed envelope scenarios followed
// by random command traffic, checked against a per-voice behavioural model.
module tb_voice_note_ctrl;

  localparam int NV    = 4;
  localparam int FW    = 24;
  localparam int AW    = 8;
  localparam int TDIV  = 4;
  localparam int ASTEP = 64;
  localparam int RSTEP = 32;
  localparam int AMAX  = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_note_ctrl_if #(.N_VOICES(NV), .FCW_W(FW), .AMP_W(AW)) bus_if ();

  voice_note_ctrl #(
    .N_VOICES(NV), .FCW_W(FW), .AMP_W(AW), .TICK_DIV(TDIV),
    .ATTACK_STEP(ASTEP), .RELEASE_STEP(RSTEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef enum {SILENT, RISING, HOLDING, FALLING} phase_e;

  typedef struct {
    logic [NV*FW-1:0] fcw;
    logic [NV*AW-1:0] amp;
    logic [NV-1:0]    act;
    logic [NV-1:0]    fin;
  } exp_t;

  exp_t exp_q[$];

  phase_e      m_phase [NV];
  int          m_amp   [NV];
  logic [FW-1:0] m_fcw [NV];
  bit          m_fin   [NV];
  int          m_cycle;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Envelope rules stated directly: ramp up by ASTEP to full scale, hold,
  // fall by RSTEP to silence; ticks every TDIV cycles counted from reset.
  task automatic model_step(input bit r, input logic [31:0] d, input logic [NV-1:0] we,
                            input bit f, input bit s, input bit rl, input bit x);
    bit tick;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_phase[i] = SILENT; m_amp[i] = 0; m_fcw[i] = '0; m_fin[i] = 0;
      end
      m_cycle = 0;
      return;
    end
    tick = (m_cycle % TDIV) == TDIV - 1;
    m_cycle++;
    for (int i = 0; i < NV; i++) begin
      if (we[i] && f) m_fcw[i] = d[FW-1:0];
      if (we[i] && x) begin
        m_phase[i] = SILENT; m_amp[i] = 0; m_fcw[i] = '0; m_fin[i] = 0;
      end else if (we[i] && s) begin
        m_phase[i] = RISING; m_fin[i] = 0;
      end else if (we[i] && rl) begin
        if (m_phase[i] == RISING || m_phase[i] == HOLDING) m_phase[i] = FALLING;
      end else if (tick) begin
        if (m_phase[i] == RISING) begin
          m_amp[i] = m_amp[i] + ASTEP;
          if (m_amp[i] >= AMAX) begin m_amp[i] = AMAX; m_phase[i] = HOLDING; end
        end else if (m_phase[i] == FALLING) begin
          m_amp[i] = m_amp[i] - RSTEP;
          if (m_amp[i] <= 0) begin m_amp[i] = 0; m_phase[i] = SILENT; m_fin[i] = 1; end
        end
      end
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.fcw = '0; e.amp = '0; e.act = '0; e.fin = '0;
    for (int i = 0; i < NV; i++) begin
      e.fcw[i*FW +: FW] = m_fcw[i];
      e.amp[i*AW +: AW] = AW'(m_amp[i]);
      e.act[i]          = (m_phase[i] != SILENT);
      e.fin[i]          = m_fin[i];
    end
    return e;
  endfunction

  task automatic drive(input bit r, input logic [31:0] d, input logic [NV-1:0] we,
                       input bit f, input bit s, input bit rl, input bit x);
    @(negedge clk);
    rst                    = r;
    bus_if.wdata           = d;
    bus_if.voice_we        = we;
    bus_if.fcw_we          = f;
    bus_if.note_start_we   = s;
    bus_if.note_release_we = rl;
    bus_if.reset_we        = x;
    model_step(r, d, we, f, s, rl, x);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every registered output update is compared with the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fcw",      bus_if.fcw,           e.fcw);
      check("amp",      bus_if.amp,           e.amp);
      check("active",   bus_if.note_active,   e.act);
      check("finished", bus_if.note_finished, e.fin);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.wdata = '0; bus_if.voice_we = '0; bus_if.fcw_we = 0;
    bus_if.note_start_we = 0; bus_if.note_release_we = 0; bus_if.reset_we = 0;

    // Reset, then FCW write to voice 0.
    drive(1'b1, 32'h0, '0, 0, 0, 0, 0);
    drive(1'b1, 32'h0, '0, 0, 0, 0, 0);
    check("rst_amp", bus_if.amp, '0);
    check("rst_active", bus_if.note_active, '0);
    drive(1'b0, 32'h00AB_CDEF, 4'b0001, 1, 0, 0, 0);
    check("fcw0_write", bus_if.fcw, 96'hAB_CDEF);

    // Attack to sustain, then full release.
    drive(1'b0, 32'h0, 4'b0001, 0, 1, 0, 0);
    check("start_active", bus_if.note_active, 4'b0001);
    idle(20);
    check("sustain_amp", bus_if.amp, 32'h0000_00FF);
    drive(1'b0, 32'h0, 4'b0001, 0, 0, 1, 0);
    idle(40);
    check("release_amp", bus_if.amp, '0);
    check("release_active", bus_if.note_active, '0);
    check("release_finished", bus_if.note_finished, 4'b0001);

    // Retrigger during release; simultaneous start+release.
    drive(1'b0, 32'h0, 4'b0001, 0, 1, 0, 0);
    check("retrig_fin_clear", bus_if.note_finished, '0);
    idle(8);
    drive(1'b0, 32'h0, 4'b0001, 0, 0, 1, 0);
    idle(5);
    drive(1'b0, 32'h0, 4'b0001, 0, 1, 0, 0);
    idle(3);
    drive(1'b0, 32'h0, 4'b0001, 0, 1, 1, 0);
    idle(6);

    // Broadcast to voices 1 and 3, then soft-reset voice 3 mid-attack.
    drive(1'b0, 32'h0012_3456, 4'b1010, 1, 1, 0, 0);
    check("bcast_active", bus_if.note_active[3:1], 3'b101);
    idle(5);
    drive(1'b0, 32'h0077_7777, 4'b1000, 1, 0, 0, 1);
    check("vreset_fcw3", bus_if.fcw[95:72], 24'h0);
    check("vreset_amp3", bus_if.amp[31:24], 8'h0);
    check("vreset_active3", bus_if.note_active[3], 1'b0);

    // Release voice 1, hard reset mid-release.
    drive(1'b0, 32'h0, 4'b0010, 0, 0, 1, 0);
    idle(3);
    drive(1'b1, 32'h0, '0, 0, 0, 0, 0);
    check("midrel_rst_amp", bus_if.amp, '0);
    check("midrel_rst_fin", bus_if.note_finished, '0);
    drive(1'b0, 32'h0, '0, 0, 0, 0, 0);

    // Random traffic: sparse strobes so envelopes get to evolve.
    for (int k = 0; k < 1500; k++) begin
      bit r, f, s, rl, x;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 19) == 0);
      rl = ($urandom_range(0, 14) == 0);
      x  = ($urandom_range(0, 59) == 0);
      drive(r, $urandom, NV'($urandom), f, s, rl, x);
    end

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
